// File: rtl/rx_block_buffer.sv
// -----------------------------------------------------------------------------
// rx_block_buffer
//
// Buffers the word stream of a multi-block SD read transfer in a fall-through
// FIFO and sequences the receiver one block at a time. A block is started only
// when the FIFO has room for all of it. While it waits for room, the buffer
// asks for the SD clock to be stopped.
//
// Optional feature (compile-time macro SDHCI_RX_ABORT_ON_ERR_EN):
//   defined   : a CRC or end-bit error on a block ends the transfer at once.
//   undefined : errors are only recorded and every block is still received.
//
// Parameters
//   MaxBlockBitSize : width of block_size_i (block size in bytes)
//   DepthWords      : FIFO depth in 32-bit words (power of two,
//                     >= 2**(MaxBlockBitSize-2))
//
// Ports
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   sd_clk_en_i                      SD clock enable strobe (shared with rx)
//   start_i, abort_i                 transfer request / abort (abort wins)
//   block_count_i, block_size_i      transfer geometry, sampled on start_i
//   rx_start_o                       one-cycle pulse that starts the receiver
//   rx_valid_i, rx_data_i            receiver word stream
//   rx_done_i                        end-of-block strobe
//   rx_crc_err_i, rx_end_bit_err_i   block errors, valid with rx_done_i
//   rd_valid_o, rd_data_o, rd_ready_i host read port (fall-through)
//   clk_stop_o                       waiting for FIFO space before a block
//   busy_o, xfer_done_o              transfer active / completion pulse
//   crc_err_o, end_bit_err_o         sticky block error flags
//   overflow_o                       sticky dropped-word flag
// -----------------------------------------------------------------------------
module rx_block_buffer #(
    parameter int MaxBlockBitSize = 10,
    parameter int DepthWords      = 256
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       sd_clk_en_i,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic [15:0]                block_count_i,
    input  logic [MaxBlockBitSize-1:0] block_size_i,
    output logic                       rx_start_o,
    input  logic                       rx_valid_i,
    input  logic [31:0]                rx_data_i,
    input  logic                       rx_done_i,
    input  logic                       rx_crc_err_i,
    input  logic                       rx_end_bit_err_i,
    output logic                       rd_valid_o,
    output logic [31:0]                rd_data_o,
    input  logic                       rd_ready_i,
    output logic                       clk_stop_o,
    output logic                       busy_o,
    output logic                       xfer_done_o,
    output logic                       crc_err_o,
    output logic                       end_bit_err_o,
    output logic                       overflow_o
);

    localparam int PtrW = $clog2(DepthWords);
    localparam int CntW = PtrW + 1;
    localparam int WpbW = MaxBlockBitSize - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_START,
        S_RECV,
        S_DONE
    } state_e;

    state_e            state_q;
    logic [15:0]       blocks_left_q;
    logic [WpbW-1:0]   wpb_q;
    logic              rx_start_q;
    logic              crc_err_q;
    logic              end_bit_err_q;
    logic              overflow_q;

    logic [31:0]       mem [DepthWords];
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [CntW-1:0]   count_q;

    // Words per block: the sum is one bit wider than block_size_i so that
    // sizes near the maximum round up instead of wrapping to a tiny value.
    logic [MaxBlockBitSize:0] wpb_sum;
    logic [WpbW-1:0]          wpb_d;
    assign wpb_sum = {1'b0, block_size_i} + (MaxBlockBitSize + 1)'(3);
    assign wpb_d   = WpbW'(wpb_sum >> 2);

    logic        fifo_empty;
    logic        fifo_full;
    logic        pop;
    logic        push;
    logic [31:0] free_words;
    logic        space_ok;
    logic        start_accept;
    logic        block_err;

    assign fifo_empty   = (count_q == '0);
    assign fifo_full    = (count_q == CntW'(DepthWords));
    assign pop          = !fifo_empty && rd_ready_i && !abort_i;
    // A word arriving on a full FIFO is still taken when the host pops the
    // head in the same cycle.
    assign push         = rx_valid_i && !abort_i && (!fifo_full || pop);
    assign free_words   = 32'(DepthWords) - 32'(count_q);
    assign space_ok     = (free_words >= 32'(wpb_q));
    assign start_accept = (state_q == S_IDLE) && start_i && !abort_i;
    assign block_err    = rx_crc_err_i || rx_end_bit_err_i;

    // Transfer sequencer.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the clock edge, whatever the block order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            blocks_left_q <= '0;
            wpb_q         <= '0;
            rx_start_q    <= 1'b0;
            crc_err_q     <= 1'b0;
            end_bit_err_q <= 1'b0;
        end else begin
            rx_start_q <= 1'b0;
            if (abort_i) begin
                state_q       <= S_IDLE;
                blocks_left_q <= '0;
            end else begin
                if (rx_done_i && rx_crc_err_i)     crc_err_q     <= 1'b1;
                if (rx_done_i && rx_end_bit_err_i) end_bit_err_q <= 1'b1;
                unique case (state_q)
                    S_IDLE: begin
                        if (start_i) begin
                            crc_err_q     <= 1'b0;
                            end_bit_err_q <= 1'b0;
                            wpb_q         <= wpb_d;
                            blocks_left_q <= block_count_i;
                            state_q       <= (block_count_i == 16'd0) ? S_DONE : S_ARM;
                        end
                    end
                    S_ARM: begin
                        if (space_ok) state_q <= S_START;
                    end
                    S_START: begin
                        if (sd_clk_en_i) begin
                            rx_start_q <= 1'b1;
                            state_q    <= S_RECV;
                        end
                    end
                    S_RECV: begin
                        if (rx_done_i) begin
                            blocks_left_q <= blocks_left_q - 16'd1;
                            state_q       <= (blocks_left_q == 16'd1) ? S_DONE : S_ARM;
`ifdef SDHCI_RX_ABORT_ON_ERR_EN
                            if (block_err) begin
                                blocks_left_q <= '0;
                                state_q       <= S_DONE;
                            end
`endif
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifndef SDHCI_RX_ABORT_ON_ERR_EN
    // Errors only feed the sticky flags in this build.
    logic unused_block_err;
    assign unused_block_err = block_err;
`endif

    // FIFO pointers, occupancy and overflow flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (abort_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Pointers wrap naturally because DepthWords is a power of two.
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push && !pop)      count_q <= count_q + CntW'(1);
            else if (pop && !push) count_q <= count_q - CntW'(1);
            if (start_accept)           overflow_q <= 1'b0;
            else if (rx_valid_i && !push) overflow_q <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset; its contents are only ever read
    // behind the occupancy count, so resetting it would only add reset fanout.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= rx_data_i;
    end

    assign rx_start_o    = rx_start_q;
    assign clk_stop_o    = (state_q == S_ARM) && !space_ok;
    assign busy_o        = (state_q != S_IDLE);
    assign xfer_done_o   = (state_q == S_DONE);
    assign crc_err_o     = crc_err_q;
    assign end_bit_err_o = end_bit_err_q;
    assign overflow_o    = overflow_q;
    assign rd_valid_o    = !fifo_empty;
    assign rd_data_o     = fifo_empty ? 32'd0 : mem[rd_ptr_q];

endmodule

// File: tb/tb_rx_block_buffer.sv
// -----------------------------------------------------------------------------
// tb_rx_block_buffer
//
// Randomised bench for rx_block_buffer. The bench plays the SD receiver and
// the host. A reference model keeps the buffered words in a queue together
// with the sticky flags, and the outputs are compared every cycle. Transfer
// level results (receiver starts, completion pulses, flags) are predicted
// from the block geometry and the injected errors.
// -----------------------------------------------------------------------------
module tb_rx_block_buffer;

    localparam int MaxBits = 10;
    localparam int Depth   = 256;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic               sd_clk_en_i;
    logic               start_i;
    logic               abort_i;
    logic [15:0]        block_count_i;
    logic [MaxBits-1:0] block_size_i;
    logic               rx_start_o;
    logic               rx_valid_i;
    logic [31:0]        rx_data_i;
    logic               rx_done_i;
    logic               rx_crc_err_i;
    logic               rx_end_bit_err_i;
    logic               rd_valid_o;
    logic [31:0]        rd_data_o;
    logic               rd_ready_i;
    logic               clk_stop_o;
    logic               busy_o;
    logic               xfer_done_o;
    logic               crc_err_o;
    logic               end_bit_err_o;
    logic               overflow_o;

    rx_block_buffer #(
        .MaxBlockBitSize(MaxBits),
        .DepthWords     (Depth)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .sd_clk_en_i     (sd_clk_en_i),
        .start_i         (start_i),
        .abort_i         (abort_i),
        .block_count_i   (block_count_i),
        .block_size_i    (block_size_i),
        .rx_start_o      (rx_start_o),
        .rx_valid_i      (rx_valid_i),
        .rx_data_i       (rx_data_i),
        .rx_done_i       (rx_done_i),
        .rx_crc_err_i    (rx_crc_err_i),
        .rx_end_bit_err_i(rx_end_bit_err_i),
        .rd_valid_o      (rd_valid_o),
        .rd_data_o       (rd_data_o),
        .rd_ready_i      (rd_ready_i),
        .clk_stop_o      (clk_stop_o),
        .busy_o          (busy_o),
        .xfer_done_o     (xfer_done_o),
        .crc_err_o       (crc_err_o),
        .end_bit_err_o   (end_bit_err_o),
        .overflow_o      (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    logic [31:0] mq[$];
    bit          m_crc;
    bit          m_end;
    bit          m_ovf;
    int          wpb_cur;
    int          start_cnt;
    int          done_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_crc = 0;
        m_end = 0;
        m_ovf = 0;
    endtask

    task automatic idle_inputs();
        sd_clk_en_i      = 1'b0;
        start_i          = 1'b0;
        abort_i          = 1'b0;
        rx_valid_i       = 1'b0;
        rx_data_i        = 32'd0;
        rx_done_i        = 1'b0;
        rx_crc_err_i     = 1'b0;
        rx_end_bit_err_i = 1'b0;
        rd_ready_i       = 1'b0;
    endtask

    // One clock: compare settled outputs against the model, advance the model
    // with the inputs applied for this cycle, then step past the next edge.
    task automatic tick();
        bit do_pop;
        bit do_push;
        check("rd_valid", rd_valid_o, (mq.size() != 0));
        if (mq.size() != 0) check("rd_data", rd_data_o, mq[0]);
        check("crc_flag", crc_err_o, m_crc);
        check("end_flag", end_bit_err_o, m_end);
        check("ovf_flag", overflow_o, m_ovf);
        check("clk_stop_with_space", clk_stop_o && ((Depth - mq.size()) >= wpb_cur), 0);
        if (rx_start_o)  start_cnt++;
        if (xfer_done_o) done_cnt++;
        if (abort_i) begin
            mq.delete();
        end else begin
            if (start_i) begin
                m_crc = 0;
                m_end = 0;
                m_ovf = 0;
            end
            do_pop  = (mq.size() != 0) && rd_ready_i;
            do_push = rx_valid_i && ((mq.size() < Depth) || do_pop);
            if (rx_valid_i && !do_push) m_ovf = 1;
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(rx_data_i);
            if (rx_done_i && rx_crc_err_i)     m_crc = 1;
            if (rx_done_i && rx_end_bit_err_i) m_end = 1;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        idle_inputs();
        rd_ready_i = 1'b1;
        for (int i = 0; i < Depth + 8 && mq.size() != 0; i++) tick();
        repeat (3) tick();
        rd_ready_i = 1'b0;
    endtask

    // Full transfer. err_blk: index of the failing block (-1 = none);
    // err_crc selects CRC (1) or end-bit (0). rmode: 0 random host,
    // 1 host always ready, 2 host stalls until the FIFO has filled past
    // two blocks and the buffer has waited 40 cycles.
    task automatic run_transfer(input int bsize, input int bcount, input int err_blk,
                                input bit err_crc, input int rmode);
        int  s0;
        int  d0;
        int  exp_blocks;
        int  blk;
        int  words_left;
        int  hold;
        bit  in_blk;
        bit  exp_crc;
        bit  exp_end;
        wpb_cur    = (bsize + 3) / 4;
        exp_blocks = bcount;
`ifdef SDHCI_RX_ABORT_ON_ERR_EN
        if (err_blk >= 0 && err_blk < bcount) exp_blocks = err_blk + 1;
`endif
        exp_crc = (err_blk >= 0) && (err_blk < bcount) && err_crc;
        exp_end = (err_blk >= 0) && (err_blk < bcount) && !err_crc;
        s0 = start_cnt;
        d0 = done_cnt;
        idle_inputs();
        block_size_i  = MaxBits'(bsize);
        block_count_i = 16'(bcount);
        start_i       = 1'b1;
        tick();
        start_i = 1'b0;
        check("busy_after_start", busy_o, 1);
        blk        = 0;
        words_left = 0;
        in_blk     = 0;
        hold       = 0;
        for (int cyc = 0; cyc < 20000 && done_cnt == d0; cyc++) begin
            rx_valid_i       = 1'b0;
            rx_done_i        = 1'b0;
            rx_crc_err_i     = 1'b0;
            rx_end_bit_err_i = 1'b0;
            sd_clk_en_i      = 1'($urandom_range(0, 1));
            if (rx_start_o) begin
                in_blk     = 1;
                words_left = wpb_cur;
            end
            if (in_blk) begin
                if (words_left > 0 && $urandom_range(0, 3) != 0) begin
                    rx_valid_i = 1'b1;
                    rx_data_i  = $urandom;
                    words_left--;
                end
                // End of block either with the last word or on a later cycle.
                if (words_left == 0 && (!rx_valid_i || $urandom_range(0, 1) == 1)) begin
                    rx_done_i = 1'b1;
                    if (blk == err_blk) begin
                        rx_crc_err_i     = err_crc;
                        rx_end_bit_err_i = !err_crc;
                    end
                    blk++;
                    in_blk = 0;
                end
            end
            case (rmode)
                0: rd_ready_i = 1'($urandom_range(0, 1));
                1: rd_ready_i = 1'b1;
                default: begin
                    if (blk < 2) begin
                        rd_ready_i = 1'b0;
                    end else if (hold < 40) begin
                        rd_ready_i = 1'b0;
                        hold++;
                        if (hold == 40) begin
                            check("clk_stop_when_full", clk_stop_o, 1);
                            check("starts_while_stalled", start_cnt - s0, 2);
                        end
                    end else begin
                        rd_ready_i = 1'b1;
                    end
                end
            endcase
            tick();
        end
        check("xfer_done_seen", done_cnt - d0, 1);
        drain();
        check("done_pulses", done_cnt - d0, 1);
        check("start_pulses", start_cnt - s0, exp_blocks);
        check("busy_end", busy_o, 0);
        check("crc_final", crc_err_o, exp_crc);
        check("end_final", end_bit_err_o, exp_end);
        check("ovf_final", overflow_o, 0);
        check("clk_stop_end", clk_stop_o, 0);
    endtask

    // Start a 512-byte, 2-block transfer and buffer n words of block 1.
    task automatic fill_first_block(input int n);
        bit in_blk;
        int sent;
        wpb_cur = 128;
        idle_inputs();
        sd_clk_en_i   = 1'b1;
        block_size_i  = MaxBits'(512);
        block_count_i = 16'd2;
        start_i       = 1'b1;
        tick();
        start_i = 1'b0;
        in_blk  = 0;
        sent    = 0;
        for (int cyc = 0; cyc < 2000 && sent < n; cyc++) begin
            rx_valid_i = 1'b0;
            if (rx_start_o || in_blk) begin
                in_blk     = 1;
                rx_valid_i = 1'b1;
                rx_data_i  = $urandom;
                sent++;
            end
            tick();
        end
        rx_valid_i = 1'b0;
        check("words_buffered", rd_valid_o, 1);
        check("busy_in_recv", busy_o, 1);
    endtask

    initial begin
        int d0;
        start_cnt     = 0;
        done_cnt      = 0;
        wpb_cur       = 0;
        block_size_i  = '0;
        block_count_i = '0;
        idle_inputs();
        model_reset();

        // Reset state.
        rst_ni = 1'b0;
        #12;
        check("rst_busy", busy_o, 0);
        check("rst_rd_valid", rd_valid_o, 0);
        check("rst_rd_data", rd_data_o, 0);
        check("rst_done", xfer_done_o, 0);
        check("rst_rx_start", rx_start_o, 0);
        check("rst_clk_stop", clk_stop_o, 0);
        check("rst_flags", {crc_err_o, end_bit_err_o, overflow_o}, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        tick();

        // Directed scenarios.
        run_transfer(512, 2, -1, 0, 1);   // clean two-block transfer
        run_transfer(512, 2, -1, 0, 2);   // host stalled, both blocks fit
        run_transfer(512, 3, -1, 0, 2);   // third block waits for space
        run_transfer(6, 3, -1, 0, 0);     // two words per block
        run_transfer(1023, 1, -1, 0, 1);  // largest block: 256 words
        run_transfer(64, 3, 0, 1, 0);     // CRC error on the first block
        run_transfer(40, 3, 1, 0, 0);     // end-bit error on the second block
        run_transfer(16, 0, -1, 0, 1);    // zero blocks

        // FIFO full: drop without a pop, accept with a pop in the same cycle.
        idle_inputs();
        wpb_cur = 0;
        for (int i = 0; i < Depth; i++) begin
            rx_valid_i = 1'b1;
            rx_data_i  = $urandom;
            tick();
        end
        rx_data_i = 32'hDEAD_BEEF;
        tick();
        check("ovf_on_full", overflow_o, 1);
        rx_data_i  = 32'hCAFE_F00D;
        rd_ready_i = 1'b1;
        tick();
        check("full_push_with_pop", rd_valid_o, 1);
        drain();
        run_transfer(100, 2, -1, 0, 0);   // accepted start clears overflow

        // Random transfers.
        for (int t = 0; t < 6; t++) begin
            int eb;
            eb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 2)) : -1;
            run_transfer(int'($urandom_range(1, 1023)), int'($urandom_range(1, 3)), eb,
                         1'($urandom_range(0, 1)), 0);
        end

        // Abort with 40 words buffered.
        fill_first_block(40);
        d0      = done_cnt;
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("abort_rd_valid", rd_valid_o, 0);
        check("abort_busy", busy_o, 0);
        repeat (10) tick();
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_stays_idle", busy_o, 0);

        // Reset in the middle of a transfer.
        fill_first_block(20);
        d0     = done_cnt;
        rst_ni = 1'b0;
        #2;
        model_reset();
        idle_inputs();
        check("midrst_busy", busy_o, 0);
        check("midrst_rd_valid", rd_valid_o, 0);
        check("midrst_rd_data", rd_data_o, 0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        repeat (10) tick();
        check("midrst_no_done", done_cnt - d0, 0);
        run_transfer(12, 2, -1, 0, 0);    // recovers after reset

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
